// File: rtl/ahb_arbiter_rr_np.sv
// Round-robin output-stage arbiter for the AHB bus matrix; holds grant over locks and bursts.
// Define AHB_ARB_PRIO_EN to add the req_prio input and priority classes ahead of round-robin.
module ahb_arbiter_rr_np #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS),
    parameter int unsigned INCR_HOLD = 4,
    parameter int unsigned EARLY_MAX = 1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_PORTS-1:0]   req_port,
    input  logic                   HREADYM,
    input  logic                   HSELM,
    input  logic [1:0]             HTRANSM,
    input  logic [2:0]             HBURSTM,
    input  logic                   HMASTLOCKM,
`ifdef AHB_ARB_PRIO_EN
    input  logic [2*NUM_PORTS-1:0] req_prio,
`endif
    output logic [PORT_W-1:0]      addr_in_port,
    output logic [NUM_PORTS-1:0]   grant_oh,
    output logic                   no_port
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [2:0] BurstIncr   = 3'd1;
    localparam logic [2:0] BurstWrap4  = 3'd2;
    localparam logic [2:0] BurstIncr4  = 3'd3;
    localparam logic [2:0] BurstWrap8  = 3'd4;
    localparam logic [2:0] BurstIncr8  = 3'd5;
    localparam logic [2:0] BurstWrap16 = 3'd6;
    localparam logic [2:0] BurstIncr16 = 3'd7;

    localparam logic [3:0]        IncrRemain = 4'(INCR_HOLD - 2);
    localparam logic [1:0]        EarlyMax   = 2'(EARLY_MAX);
    localparam logic [PORT_W-1:0] LastPort   = PORT_W'(NUM_PORTS - 1);

    logic [3:0]           remain_q, remain_d;
    logic                 hold_q, hold_d;
    logic [1:0]           early_q, early_d, early_now;
    logic [PORT_W-1:0]    addr_q, addr_d;
    logic                 no_port_q, no_port_d;
    logic                 started_q, started_d;
    logic [NUM_PORTS-1:0] cand;
    logic [PORT_W-1:0]    rr_base, rr_win;
    logic                 rr_found;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain_q  <= 4'd0;
            hold_q    <= 1'b0;
            early_q   <= 2'd0;
            addr_q    <= '0;
            no_port_q <= 1'b1;
            started_q <= 1'b0;
        end else if (HREADYM) begin
            remain_q  <= remain_d;
            hold_q    <= hold_d;
            early_q   <= early_d;
            addr_q    <= addr_d;
            no_port_q <= no_port_d;
            started_q <= started_d;
        end
    end

    // A NONSEQ arriving while still holding ends the previous INCR early; it counts at once
    // so the burst that would exceed EARLY_MAX is already refused its hold.
    always_comb begin
        early_now = early_q;
        if (hold_q && (HTRANSM == TransNonseq) && (early_q < EarlyMax)) begin
            early_now = early_q + 2'd1;
        end
    end

    always_comb begin
        remain_d = remain_q;
        hold_d   = hold_q;
        if (!HSELM || (HTRANSM == TransIdle)) begin
            remain_d = 4'd0;
            hold_d   = 1'b0;
        end else begin
            case (HTRANSM)
                TransNonseq: begin
                    unique case (HBURSTM)
                        BurstWrap16, BurstIncr16: begin
                            remain_d = 4'd14;
                            hold_d   = 1'b1;
                        end
                        BurstWrap8, BurstIncr8: begin
                            remain_d = 4'd6;
                            hold_d   = 1'b1;
                        end
                        BurstWrap4, BurstIncr4: begin
                            remain_d = 4'd2;
                            hold_d   = 1'b1;
                        end
                        BurstIncr: begin
                            if (early_now == EarlyMax) begin
                                remain_d = 4'd0;
                                hold_d   = 1'b0;
                            end else begin
                                remain_d = IncrRemain;
                                hold_d   = 1'b1;
                            end
                        end
                        default: begin
                            remain_d = 4'd0;
                            hold_d   = 1'b0;
                        end
                    endcase
                end
                TransSeq: begin
                    if (remain_q == 4'd0) begin
                        hold_d = 1'b0;
                    end else begin
                        remain_d = remain_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign early_d = hold_d ? early_now : 2'd0;

`ifdef AHB_ARB_PRIO_EN
    logic [1:0] prio_top;

    always_comb begin
        prio_top = 2'd0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (req_port[i] && (req_prio[2*i +: 2] > prio_top)) begin
                prio_top = req_prio[2*i +: 2];
            end
        end
        cand = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            cand[i] = req_port[i] && (req_prio[2*i +: 2] == prio_top);
        end
    end
`else
    assign cand = req_port;
`endif

    // Until the first grant after reset, search as if the last port had owned the bus,
    // so port 0 is examined first.
    always_comb begin
        rr_base  = started_q ? addr_q : LastPort;
        rr_found = 1'b0;
        rr_win   = rr_base;
        for (int k = 1; k <= int'(NUM_PORTS); k++) begin
            if (!rr_found && cand[PORT_W'((int'(rr_base) + k) % int'(NUM_PORTS))]) begin
                rr_found = 1'b1;
                rr_win   = PORT_W'((int'(rr_base) + k) % int'(NUM_PORTS));
            end
        end
    end

    always_comb begin
        addr_d    = addr_q;
        no_port_d = no_port_q;
        started_d = started_q;
        if (!(HMASTLOCKM || hold_d)) begin
            if (rr_found) begin
                addr_d    = rr_win;
                no_port_d = 1'b0;
                started_d = 1'b1;
            end else if (!no_port_q && HSELM) begin
                no_port_d = 1'b0;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (!no_port_q) begin
            grant_oh[addr_q] = 1'b1;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_arbiter_rr_np.sv
// Bench for ahb_arbiter_rr_np: beat-counting reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_ahb_arbiter_rr_np;

    localparam int NP = 4;
    localparam int IH = 4;
    localparam int EM = 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    typedef struct packed {
        int addr;
        bit np;
        bit started;
        int beat;
        int len;
        bit hold;
        int early;
    } mstate_t;

    logic       HCLK;
    logic       HRESETn;
    logic       HREADYM;
    logic       HSELM;
    logic       HMASTLOCKM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [3:0] req_port;
    logic [7:0] req_prio;
    logic [1:0] addr_in_port;
    logic [3:0] grant_oh;
    logic       no_port;

    int n_checks = 0;
    int n_fail   = 0;

    logic       lit_en = 1'b0;
    int         lit_addr;
    logic       lit_np;
    logic [3:0] lit_oh;

    mstate_t m;

    ahb_arbiter_rr_np #(
        .NUM_PORTS (NP),
        .INCR_HOLD (IH),
        .EARLY_MAX (EM)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
`ifdef AHB_ARB_PRIO_EN
        .req_prio     (req_prio),
`endif
        .addr_in_port (addr_in_port),
        .grant_oh     (grant_oh),
        .no_port      (no_port)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Burst tracked as beat number against burst length; grant by scanning ports.
    function automatic mstate_t model_next(input mstate_t s, input logic [3:0] r,
                                           input logic sel, input logic [1:0] tr,
                                           input logic [2:0] bu, input logic lk,
                                           input logic [7:0] pr);
        mstate_t    n;
        int         early_now;
        int         top;
        int         base;
        int         p;
        bit         found;
        logic [3:0] cand;
        n = s;
        early_now = s.early;
        if (s.hold && tr == NSEQ && s.early < EM) early_now = s.early + 1;
        if (!sel || tr == IDLE) begin
            n.hold = 0;
            n.beat = 0;
            n.len  = 0;
        end else if (tr == NSEQ) begin
            case (bu)
                SINGLE:       n.len = 1;
                INCR:         n.len = (early_now == EM) ? 1 : IH;
                3'd2, 3'd3:   n.len = 4;
                3'd4, 3'd5:   n.len = 8;
                default:      n.len = 16;
            endcase
            n.beat = 1;
            n.hold = (n.beat < n.len);
        end else if (tr == SEQ) begin
            if (s.hold) begin
                n.beat = s.beat + 1;
                n.hold = (n.beat < s.len);
            end else begin
                n.hold = 0;
            end
        end
        n.early = n.hold ? early_now : 0;
        if (!lk && !n.hold) begin
            top = 0;
            for (int i = 0; i < NP; i++) begin
                if (r[i] && int'(pr[2*i +: 2]) > top) top = int'(pr[2*i +: 2]);
            end
            for (int i = 0; i < NP; i++) begin
                cand[i] = r[i] && (int'(pr[2*i +: 2]) == top);
            end
            base  = s.started ? s.addr : NP - 1;
            found = 0;
            for (int k = 1; k <= NP; k++) begin
                p = (base + k) % NP;
                if (!found && cand[p[1:0]]) begin
                    found  = 1;
                    n.addr = p;
                end
            end
            if (found) begin
                n.np      = 0;
                n.started = 1;
            end else begin
                n.np = !(!s.np && sel);
            end
        end
        return n;
    endfunction

    initial begin
        m    = '0;
        m.np = 1'b1;
        forever begin
            @(posedge HCLK or negedge HRESETn);
            if (!HRESETn) begin
                m    = '0;
                m.np = 1'b1;
            end else if (HREADYM) begin
                m = model_next(m, req_port, HSELM, HTRANSM, HBURSTM, HMASTLOCKM, req_prio);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] exp_oh;
        @(posedge HCLK);
        forever begin
            @(negedge HCLK);
            exp_oh = m.np ? 4'b0000 : (4'b0001 << m.addr);
            chk("model_addr", 32'(addr_in_port), m.addr);
            chk("model_no_port", 32'(no_port), 32'(m.np));
            chk("model_grant_oh", 32'(grant_oh), 32'(exp_oh));
            if (lit_en) begin
                chk("lit_addr", 32'(addr_in_port), lit_addr);
                chk("lit_no_port", 32'(no_port), 32'(lit_np));
                chk("lit_grant_oh", 32'(grant_oh), 32'(lit_oh));
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input logic rdy, input logic sel,
                       input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        @(negedge HCLK);
        #1;
        req_port   = r;
        HREADYM    = rdy;
        HSELM      = sel;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
        lit_en     = 1'b0;
    endtask

    task automatic lit(input int a, input logic np, input logic [3:0] oh);
        lit_en   = 1'b1;
        lit_addr = a;
        lit_np   = np;
        lit_oh   = oh;
    endtask

    localparam logic [1:0] ST_TR [13] = '{NSEQ, BUSY, SEQ, SEQ, SEQ, SEQ, BUSY,
                                          SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    localparam logic       ST_RDY[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                          1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        HRESETn    = 1'b0;
        req_port   = 4'b0000;
        HREADYM    = 1'b0;
        HSELM      = 1'b0;
        HTRANSM    = IDLE;
        HBURSTM    = SINGLE;
        HMASTLOCKM = 1'b0;
        req_prio   = 8'h00;

        // reset, then first grant goes to port 0 and rotates
        cyc(4'b0101, 1, 0, IDLE, SINGLE, 0); lit(0, 1, 4'b0000);
        cyc(4'b0101, 1, 0, IDLE, SINGLE, 0); HRESETn = 1'b1; lit(0, 0, 4'b0001);
        cyc(4'b0101, 1, 0, IDLE, SINGLE, 0); lit(2, 0, 4'b0100);
        cyc(4'b0101, 1, 0, IDLE, SINGLE, 0); lit(0, 0, 4'b0001);

        // INCR8 on owner 1 holds for 8 beats
        cyc(4'b0010, 1, 0, IDLE, SINGLE, 0); lit(1, 0, 4'b0010);
        cyc(4'b1111, 1, 1, NSEQ, INCR8, 0); lit(1, 0, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            cyc(4'b1111, 1, 1, SEQ, INCR8, 0); lit(1, 0, 4'b0010);
        end
        cyc(4'b1111, 1, 1, SEQ, INCR8, 0); lit(2, 0, 4'b0100);

        // INCR8 on owner 2 with BUSY and wait states: still 8 real beats
        for (int i = 0; i < 13; i++) begin
            cyc(4'b1111, ST_RDY[i], 1, ST_TR[i], INCR8, 0);
            if (i == 12) lit(3, 0, 4'b1000);
            else         lit(2, 0, 4'b0100);
        end

        // short INCR followed by INCR: second one is refused a hold
        cyc(4'b0001, 1, 0, IDLE, SINGLE, 0); lit(0, 0, 4'b0001);
        cyc(4'b1001, 1, 1, NSEQ, INCR, 0);   lit(0, 0, 4'b0001);
        cyc(4'b1001, 1, 1, SEQ, INCR, 0);    lit(0, 0, 4'b0001);
        cyc(4'b1001, 1, 1, SEQ, INCR, 0);    lit(0, 0, 4'b0001);
        cyc(4'b1001, 1, 1, NSEQ, INCR, 0);   lit(3, 0, 4'b1000);

        // locked owner 2 for 20 cycles
        cyc(4'b0100, 1, 0, IDLE, SINGLE, 0); lit(2, 0, 4'b0100);
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1011, 1, 1, NSEQ, SINGLE, 1); lit(2, 0, 4'b0100);
        end
        cyc(4'b1011, 1, 1, IDLE, SINGLE, 0); lit(3, 0, 4'b1000);

        // parking with no requesters
        cyc(4'b0010, 1, 0, IDLE, SINGLE, 0); lit(1, 0, 4'b0010);
        cyc(4'b0000, 1, 1, IDLE, SINGLE, 0); lit(1, 0, 4'b0010);
        cyc(4'b0000, 1, 1, IDLE, SINGLE, 0); lit(1, 0, 4'b0010);
        cyc(4'b0000, 1, 0, IDLE, SINGLE, 0); lit(1, 1, 4'b0000);
        cyc(4'b0000, 1, 1, IDLE, SINGLE, 0); lit(1, 1, 4'b0000);

        // deselect mid-burst re-arbitrates immediately
        cyc(4'b0010, 1, 0, IDLE, SINGLE, 0); lit(1, 0, 4'b0010);
        cyc(4'b0110, 1, 1, NSEQ, INCR16, 0); lit(1, 0, 4'b0010);
        cyc(4'b0110, 1, 1, SEQ, INCR16, 0);  lit(1, 0, 4'b0010);
        cyc(4'b0110, 1, 0, SEQ, INCR16, 0);  lit(2, 0, 4'b0100);

        // async reset mid-burst
        cyc(4'b1111, 1, 1, NSEQ, INCR4, 0);  lit(2, 0, 4'b0100);
        cyc(4'b1111, 1, 1, SEQ, INCR4, 0);   lit(2, 0, 4'b0100);
        cyc(4'b0101, 1, 1, SEQ, INCR4, 0);
        #2;
        HRESETn = 1'b0;
        lit(0, 1, 4'b0000);
        cyc(4'b0101, 1, 0, IDLE, SINGLE, 0); HRESETn = 1'b1; lit(0, 0, 4'b0001);
        cyc(4'b0101, 1, 0, IDLE, SINGLE, 0); lit(2, 0, 4'b0100);

`ifdef AHB_ARB_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0111, 1, 0, IDLE, SINGLE, 0); req_prio = 8'b00_01_11_01; lit(1, 0, 4'b0010);
        end
        cyc(4'b0111, 1, 0, IDLE, SINGLE, 0); req_prio = 8'b00_01_01_01; lit(2, 0, 4'b0100);
        cyc(4'b0111, 1, 0, IDLE, SINGLE, 0); lit(0, 0, 4'b0001);
        cyc(4'b0111, 1, 0, IDLE, SINGLE, 0); lit(1, 0, 4'b0010);
`endif

        @(negedge HCLK);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
